// File: rtl/mul32_ctrl.sv
// Sequencer that wraps an unsigned 32x32 multiplier core to provide the
// MUL/MULH/MULHSU/MULHU operations with a valid/ready request and result handshake.
module mul32_ctrl #(
    parameter int CORE_LAT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  funct,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        mul_rst,
    output logic [31:0] mul_op1,
    output logic [31:0] mul_op2,
    input  logic [63:0] mul_res
);

    typedef enum logic [2:0] {IDLE, LOAD, BUSY, FIX, DONE} state_t;

    localparam logic [5:0] LAST_CNT = 6'(CORE_LAT - 1);

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [31:0] res_q;
    logic        mul_rst_q;
    logic [31:0] mul_op1_q;
    logic [31:0] mul_op2_q;
    logic [63:0] prod_q;
    logic [1:0]  funct_q;
    logic        neg_q;

    logic        op1_neg_d;
    logic        op2_neg_d;
    logic [31:0] op1_mag_d;
    logic [31:0] op2_mag_d;
    logic [63:0] prod_fix_d;

    // op1 is signed for MULH/MULHSU, op2 only for MULH; MUL uses raw bits.
    always_comb begin
        op1_neg_d  = (funct == 2'b01 || funct == 2'b10) && op1[31];
        op2_neg_d  = (funct == 2'b01) && op2[31];
        op1_mag_d  = op1_neg_d ? (~op1 + 32'd1) : op1;
        op2_mag_d  = op2_neg_d ? (~op2 + 32'd1) : op2;
        prod_fix_d = neg_q ? (~prod_q + 64'd1) : prod_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= 32'd0;
            mul_rst_q   <= 1'b1;
            mul_op1_q   <= 32'd0;
            mul_op2_q   <= 32'd0;
            prod_q      <= 64'd0;
            funct_q     <= 2'b00;
            neg_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        funct_q    <= funct;
                        neg_q      <= op1_neg_d ^ op2_neg_d;
                        mul_op1_q  <= op1_mag_d;
                        mul_op2_q  <= op2_mag_d;
                        in_ready_q <= 1'b0;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    mul_rst_q <= 1'b0;
                    cnt_q     <= 6'd0;
                    state_q   <= BUSY;
                end
                BUSY: begin
                    if (cnt_q == LAST_CNT) begin
                        prod_q  <= mul_res;
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                FIX: begin
                    prod_q      <= prod_fix_d;
                    res_q       <= (funct_q == 2'b00) ? prod_fix_d[31:0] : prod_fix_d[63:32];
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    // in_ready only rises after the result handshake edge.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        mul_rst_q   <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign mul_rst   = mul_rst_q;
    assign mul_op1   = mul_op1_q;
    assign mul_op2   = mul_op2_q;

endmodule
